// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, grant-select
// constants and the address alignment helper.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_ERR_I  = 3'd3,
    ST_ERR_D  = 3'd4
  } state_e;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/mem_arbiter_arb.sv
// Two-input grant select: data has priority unless fairness hands the turn
// to the fetch port right after a data grant.
module arb_prio2
  import mem_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic gnt_valid,
  output logic gnt_sel
);

  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_sel   = GNT_I;
    if (req_i && req_d) begin
      gnt_sel = (FAIR && last_d) ? GNT_I : GNT_D;
    end else if (req_d) begin
      gnt_sel = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory channel,
// one transaction at a time, with misaligned-address rejection.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_data,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  input  logic              m_err,
  output state_e            dbg_state
);

  // Handshake: a port raises x_req (level) with stable address/data and keeps
  // it up until x_done pulses for one cycle; m_rd/m_wr stay up until m_done.
  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic              wr_q, wr_d;
  logic              m_rd_q, m_rd_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              gnt_valid;
  logic              gnt_sel;

  arb_prio2 #(.FAIR(FAIR)) u_arb (
    .req_i     (i_req),
    .req_d     (d_req),
    .last_d    (last_d_q),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    wr_d      = wr_q;
    m_rd_d    = m_rd_q;
    m_wr_d    = m_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          last_d_d = gnt_sel;
          if (gnt_sel == GNT_D) begin
            wr_d      = d_wr;
            m_addr_d  = align_addr(d_addr);
            m_wdata_d = d_wr ? d_wdata : '0;
            if (d_addr[0]) begin
              state_d = ST_ERR_D;
            end else begin
              state_d = ST_BUSY_D;
              m_rd_d  = ~d_wr;
              m_wr_d  = d_wr;
            end
          end else begin
            wr_d      = 1'b0;
            m_addr_d  = align_addr(i_addr);
            m_wdata_d = '0;
            if (i_addr[0]) begin
              state_d = ST_ERR_I;
            end else begin
              state_d = ST_BUSY_I;
              m_rd_d  = 1'b1;
              m_wr_d  = 1'b0;
            end
          end
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (m_done) begin
          state_d = ST_IDLE;
          m_rd_d  = 1'b0;
          m_wr_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_d_q  <= GNT_I;
      wr_q      <= 1'b0;
      m_rd_q    <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      wr_q      <= wr_d;
      m_rd_q    <= m_rd_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  // Completion is reported in the same cycle the memory finishes.
  logic fin_i, fin_d;
  assign fin_i = (state_q == ST_BUSY_I) && m_done;
  assign fin_d = (state_q == ST_BUSY_D) && m_done;

  assign i_done  = fin_i || (state_q == ST_ERR_I);
  assign i_err   = (fin_i && m_err) || (state_q == ST_ERR_I);
  assign i_data  = fin_i ? m_rdata : '0;
  assign d_done  = fin_d || (state_q == ST_ERR_D);
  assign d_err   = (fin_d && m_err) || (state_q == ST_ERR_D);
  assign d_rdata = (fin_d && !wr_q) ? m_rdata : '0;

  assign m_rd      = m_rd_q;
  assign m_wr      = m_wr_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences
// and randomized two-port traffic against a word-level memory model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic i_req, d_req, d_wr, i_done, i_err, d_done, d_err;
  logic [15:0] i_addr, d_addr, d_wdata, i_data, d_rdata;
  logic m_rd, m_wr, m_done, m_err;
  logic [15:0] m_addr, m_wdata, m_rdata;
  state_e dbg_state;

  logic f0_i_req, f0_d_req, f0_d_wr, f0_i_done, f0_i_err, f0_d_done, f0_d_err;
  logic [15:0] f0_i_addr, f0_d_addr, f0_d_wdata, f0_i_data, f0_d_rdata;
  logic f0_m_rd, f0_m_wr, f0_m_done, f0_m_err;
  logic [15:0] f0_m_addr, f0_m_wdata, f0_m_rdata;
  state_e f0_dbg_state;

  mem_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_err(i_err),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err), .dbg_state(dbg_state)
  );

  mem_arbiter #(.FAIR(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(f0_i_req), .i_addr(f0_i_addr), .i_data(f0_i_data), .i_done(f0_i_done), .i_err(f0_i_err),
    .d_req(f0_d_req), .d_wr(f0_d_wr), .d_addr(f0_d_addr), .d_wdata(f0_d_wdata),
    .d_rdata(f0_d_rdata), .d_done(f0_d_done), .d_err(f0_d_err),
    .m_rd(f0_m_rd), .m_wr(f0_m_wr), .m_addr(f0_m_addr), .m_wdata(f0_m_wdata),
    .m_rdata(f0_m_rdata), .m_done(f0_m_done), .m_err(f0_m_err), .dbg_state(f0_dbg_state)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- memory system and reference model ----------------
  logic [15:0] mem [0:127];
  logic [15:0] ref_mem [0:127];

  function automatic logic [15:0] init_word(input int idx);
    return 16'(idx * 257) ^ 16'h5A5A;
  endfunction

  int lat_min = 0, lat_max = 0, err_pct = 0, rsp_cnt = 0;
  bit force_err = 0, rsp_busy = 0, last_inj = 0;

  always begin
    @(posedge clk); #1;
    if (!rst) begin
      rsp_busy = 0; m_done = 0; m_err = 0;
    end else if (m_done) begin
      m_done = 0; m_err = 0;
    end else if (m_rd || m_wr) begin
      if (!rsp_busy) begin
        rsp_busy = 1;
        rsp_cnt = $urandom_range(lat_max, lat_min);
      end
      if (rsp_cnt == 0) begin
        last_inj = force_err || ($urandom_range(99, 0) < err_pct);
        m_done = 1;
        m_err = last_inj;
        m_rdata = m_rd ? mem[m_addr[7:1]] : 16'($urandom);
        if (m_wr && !last_inj) mem[m_addr[7:1]] = m_wdata;
        rsp_busy = 0;
      end else begin
        rsp_cnt--;
      end
    end
  end

  // FAIR=0 instance gets a fixed one-cycle memory
  always begin
    @(posedge clk); #1;
    if (!rst) f0_m_done = 0;
    else f0_m_done = (f0_m_rd || f0_m_wr) && !f0_m_done;
  end

  // ---------------- monitor ----------------
  int proto_err = 0, cmd_cycles = 0, i_done_cnt = 0, d_done_cnt = 0;
  int f0_i_cnt = 0, f0_d_cnt = 0;
  logic [16:0] cmd_q [$];
  logic [0:0] done_q [$];
  logic [0:0] exp_q [$];
  bit cmd_prev = 0, prev_wr = 0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (m_rd && m_wr) proto_err++;
      if (m_addr[0]) proto_err++;
      if ((m_rd || m_wr) && cmd_prev && (m_addr != prev_addr || m_wr != prev_wr)) proto_err++;
      if ((m_rd || m_wr) && !cmd_prev) cmd_q.push_back({m_wr, m_addr});
      if (m_rd || m_wr) cmd_cycles++;
    end
    if (i_done && d_done) proto_err++;
    if (f0_i_done && f0_d_done) proto_err++;
    if (i_done) begin i_done_cnt++; done_q.push_back(1'b0); end
    if (d_done) begin d_done_cnt++; done_q.push_back(1'b1); end
    if (f0_i_done) f0_i_cnt++;
    if (f0_d_done) f0_d_cnt++;
    cmd_prev = m_rd || m_wr;
    prev_addr = m_addr;
    prev_wr = m_wr;
  end

  // ---------------- driver ----------------
  task automatic port_txn(input bit is_d, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output bit seen,
                          output logic [15:0] data, output bit err, output bit inj,
                          output int n);
    @(posedge clk); #1;
    if (is_d) begin d_req = 1; d_wr = wr; d_addr = addr; d_wdata = wdata; end
    else begin i_req = 1; i_addr = addr; end
    seen = 0; n = 0; data = '0; err = 0; inj = 0;
    while (!seen && n < 60) begin
      @(negedge clk); n++;
      if (is_d ? d_done : i_done) begin
        seen = 1;
        data = is_d ? d_rdata : i_data;
        err = is_d ? d_err : i_err;
        inj = last_inj;
      end
    end
    @(posedge clk); #1;
    if (is_d) d_req = 0; else i_req = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
  endtask

  typedef struct {
    bit is_d; bit wr; logic [15:0] addr; logic [15:0] wdata; int lat; bit ferr;
    logic [15:0] exp_data; bit exp_err; int exp_n;
  } vec_t;
  vec_t vecs [11];

  task automatic run_vec(input int k, input vec_t v);
    bit seen, err, inj;
    logic [15:0] data;
    int n, c0, q0, oth0;
    lat_min = v.lat; lat_max = v.lat; force_err = v.ferr;
    c0 = cmd_cycles; q0 = cmd_q.size();
    oth0 = v.is_d ? i_done_cnt : d_done_cnt;
    port_txn(v.is_d, v.wr, v.addr, v.wdata, seen, data, err, inj, n);
    force_err = 0;
    check($sformatf("v%0d_done", k), seen, 1);
    check($sformatf("v%0d_latency", k), n, v.exp_n);
    check($sformatf("v%0d_err", k), err, v.exp_err);
    if (!v.wr && !v.exp_err) check($sformatf("v%0d_data", k), data, v.exp_data);
    check($sformatf("v%0d_other_done", k), v.is_d ? i_done_cnt : d_done_cnt, oth0);
    if (v.addr[0]) begin
      check($sformatf("v%0d_no_cmd", k), cmd_cycles, c0);
    end else begin
      check($sformatf("v%0d_cmd_count", k), cmd_q.size(), q0 + 1);
      if (cmd_q.size() > q0)
        check($sformatf("v%0d_cmd", k), cmd_q[q0], {v.wr, v.addr[15:1], 1'b0});
    end
    if (v.is_d && v.wr && !v.exp_err) ref_mem[v.addr[7:1]] = v.wdata;
  endtask

  task automatic rand_port(input bit is_d, input int count);
    bit seen, err, inj, wr, exp_err;
    logic [15:0] data, addr, wdata;
    int n, idx;
    for (int t = 0; t < count; t++) begin
      wr = is_d ? bit'($urandom_range(1, 0)) : 1'b0;
      idx = !is_d ? $urandom_range(63, 0) : (wr ? $urandom_range(127, 64) : $urandom_range(127, 0));
      addr = {8'h00, 7'(idx), 1'b0};
      if ($urandom_range(7, 0) == 0) addr[0] = 1'b1;
      wdata = 16'($urandom);
      port_txn(is_d, wr, addr, wdata, seen, data, err, inj, n);
      exp_err = addr[0] || inj;
      check(is_d ? "rand_d_done" : "rand_i_done", seen, 1);
      check(is_d ? "rand_d_err" : "rand_i_err", err, exp_err);
      if (!wr && !exp_err) check(is_d ? "rand_d_data" : "rand_i_data", data, ref_mem[idx]);
      if (wr && !exp_err) ref_mem[idx] = wdata;
      repeat ($urandom_range(2, 0)) @(posedge clk);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit last_d_model;
    bit seen, err, inj;
    logic [15:0] data;
    int n, q0, i0, d0, f0d0;

    rst = 0;
    i_req = 0; i_addr = 0; d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    m_rdata = 0; m_done = 0; m_err = 0;
    f0_i_req = 0; f0_i_addr = 0; f0_d_req = 0; f0_d_wr = 0; f0_d_addr = 0; f0_d_wdata = 0;
    f0_m_rdata = 0; f0_m_done = 0; f0_m_err = 0;
    for (int k = 0; k < 128; k++) begin mem[k] = init_word(k); ref_mem[k] = init_word(k); end
    mem[8] = 16'hBEEF; ref_mem[8] = 16'hBEEF;

    vecs[0]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 3, 1'b0, 16'hBEEF, 1'b0, 5};
    vecs[1]  = '{1'b1, 1'b1, 16'h0080, 16'h1234, 1, 1'b0, 16'h0000, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 16'h0080, 16'h0000, 0, 1'b0, 16'h1234, 1'b0, 2};
    vecs[3]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 0, 1'b0, 16'h0000, 1'b1, 2};
    vecs[4]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 0, 1'b0, 16'h0000, 1'b1, 2};
    vecs[5]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2, 1'b1, 16'h0000, 1'b1, 4};
    vecs[6]  = '{1'b0, 1'b0, 16'h007E, 16'h0000, 0, 1'b0, init_word(63), 1'b0, 2};
    vecs[7]  = '{1'b1, 1'b1, 16'h00FE, 16'hFFFF, 4, 1'b0, 16'h0000, 1'b0, 6};
    vecs[8]  = '{1'b1, 1'b0, 16'h00FE, 16'h0000, 1, 1'b0, 16'hFFFF, 1'b0, 3};
    vecs[9]  = '{1'b1, 1'b1, 16'h0091, 16'hDEAD, 0, 1'b0, 16'h0000, 1'b1, 2};
    vecs[10] = '{1'b1, 1'b0, 16'h0090, 16'h0000, 0, 1'b0, init_word(72), 1'b0, 2};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_cmd", {m_rd, m_wr}, 2'b00);
    check("rst_addr", m_addr, 16'h0000);
    check("rst_wdata", m_wdata, 16'h0000);
    check("rst_done_err", {i_done, i_err, d_done, d_err}, 4'b0000);
    check("rst_data", {i_data, d_rdata}, 32'h0);
    check("rst_f0_cmd", {f0_m_rd, f0_m_wr, f0_i_done, f0_d_done}, 4'b0000);
    rst = 1;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);

    // memory completion while idle is ignored
    i0 = i_done_cnt; d0 = d_done_cnt;
    @(posedge clk); #1 m_rdata = 16'h1111; m_done = 1;
    @(negedge clk);
    check("idle_mdone_no_done", {i_done, d_done}, 2'b00);
    repeat (2) @(negedge clk);
    check("idle_mdone_state", dbg_state, ST_IDLE);
    check("idle_mdone_counts", i_done_cnt + d_done_cnt, i0 + d0);

    // request dropped mid-transaction still completes
    lat_min = 4; lat_max = 4;
    q0 = cmd_q.size(); i0 = i_done_cnt;
    @(posedge clk); #1 i_req = 1; i_addr = 16'h0016;
    n = 0;
    while (!m_rd && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 i_req = 0;
    seen = 0; n = 0;
    while (!seen && n < 20) begin
      @(negedge clk); n++;
      if (i_done) begin seen = 1; data = i_data; end
    end
    check("drop_req_done", seen, 1);
    check("drop_req_data", data, ref_mem[11]);
    repeat (4) @(negedge clk);
    check("drop_req_one_cmd", cmd_q.size(), q0 + 1);
    check("drop_req_one_done", i_done_cnt, i0 + 1);

    // simultaneous requests, FAIR=1: grants alternate starting with data
    pulse_reset();
    lat_min = 1; lat_max = 1;
    last_d_model = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(last_d_model ? 1'b0 : 1'b1);
      last_d_model = !last_d_model;
    end
    done_q.delete(); q0 = cmd_q.size();
    @(posedge clk); #1;
    d_req = 1; d_wr = 1; d_addr = 16'h0082; d_wdata = 16'hA5A5;
    i_req = 1; i_addr = 16'h0012;
    n = 0;
    while (done_q.size() < 4 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 d_req = 0; i_req = 0;
    check("fair_dones_seen", done_q.size() >= 4, 1);
    for (int k = 0; k < 4; k++)
      if (k < done_q.size()) check($sformatf("fair_order%0d", k), done_q[k], exp_q[k]);
    if (cmd_q.size() >= q0 + 2) begin
      check("fair_first_cmd", cmd_q[q0], {1'b1, 16'h0082});
      check("fair_second_cmd", cmd_q[q0 + 1], {1'b0, 16'h0012});
    end else begin
      check("fair_cmd_count", cmd_q.size(), q0 + 2);
    end
    n = 0;
    while ((m_rd || m_wr || dbg_state != ST_IDLE) && n < 50) begin @(negedge clk); n++; end
    ref_mem[65] = 16'hA5A5;

    // simultaneous requests, FAIR=0: data starves fetch while held
    f0d0 = f0_d_cnt; i0 = f0_i_cnt;
    @(posedge clk); #1;
    f0_d_req = 1; f0_d_wr = 0; f0_d_addr = 16'h0004;
    f0_i_req = 1; f0_i_addr = 16'h0008;
    repeat (30) @(posedge clk);
    check("nofair_fetch_starved", f0_i_cnt, i0);
    check("nofair_data_served", (f0_d_cnt - f0d0) >= 10, 1);
    #1 f0_d_req = 0;
    n = 0;
    while (f0_i_cnt == i0 && n < 20) begin @(negedge clk); n++; end
    check("nofair_fetch_after_drop", f0_i_cnt, i0 + 1);
    @(posedge clk); #1 f0_i_req = 0;

    // reset two cycles into BUSY_I
    lat_min = 10; lat_max = 10;
    i0 = i_done_cnt;
    @(posedge clk); #1 i_req = 1; i_addr = 16'h0014;
    n = 0;
    while (!m_rd && n < 20) begin @(negedge clk); n++; end
    check("rstmid_busy", dbg_state, ST_BUSY_I);
    @(posedge clk); @(posedge clk); #2 rst = 0;
    #1;
    check("rstmid_async_drop", {m_rd, m_wr}, 2'b00);
    check("rstmid_idle", dbg_state, ST_IDLE);
    lat_min = 2; lat_max = 2;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    check("rstmid_no_done", i_done_cnt, i0);
    seen = 0; n = 0;
    while (!seen && n < 30) begin
      @(negedge clk); n++;
      if (i_done) begin seen = 1; data = i_data; err = i_err; end
    end
    check("rstmid_regrant_done", seen, 1);
    check("rstmid_regrant_data", data, ref_mem[10]);
    check("rstmid_regrant_err", err, 0);
    @(posedge clk); #1 i_req = 0;
    repeat (2) @(posedge clk);

    // random two-port traffic
    lat_min = 0; lat_max = 4; err_pct = 10;
    fork
      rand_port(1'b0, 30);
      rand_port(1'b1, 30);
    join
    err_pct = 0;
    repeat (4) @(posedge clk);

    check("protocol_violations", proto_err, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
